// File: rtl/bp_fe_pkg.sv
// Shared defaults and types for the front-end fetch queue.
package bp_fe_pkg;

  localparam int unsigned fe_queue_els_dp           = 8;
  localparam int unsigned fe_vaddr_width_dp         = 39;
  localparam int unsigned fe_instr_width_dp         = 32;
  localparam int unsigned fe_branch_metadata_width_dp = 36;

  // Update applied to a wrap-bit pointer in one cycle, highest priority last-listed wins
  typedef enum logic [1:0] {
    ptr_hold,
    ptr_inc,
    ptr_load,
    ptr_clear
  } ptr_op_e;

endpackage

// File: rtl/bp_fe_queue_ptr.sv
// Wrap-bit queue pointer: clear > load > increment > hold.
module bp_fe_queue_ptr
  import bp_fe_pkg::*;
#(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               clr_i,
  output logic [width_p-1:0] ptr_o
);

  ptr_op_e            op;
  logic [width_p-1:0] ptr_next;

  // Resolve the competing update requests into one operation
  always_comb begin
    op = ptr_hold;
    if (clr_i)       op = ptr_clear;
    else if (load_i) op = ptr_load;
    else if (inc_i)  op = ptr_inc;
  end

  // Next pointer value for the selected operation
  always_comb begin
    ptr_next = ptr_o;
    case (op)
      ptr_clear: ptr_next = '0;
      ptr_load:  ptr_next = load_val_i;
      ptr_inc:   ptr_next = ptr_o + width_p'(1);
      default:   ptr_next = ptr_o;
    endcase
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_o <= '0;
    else            ptr_o <= ptr_next;
  end

endmodule

// File: rtl/bp_fe_fetch_queue.sv
// Fetch packet queue between PC gen and the backend, with speculative
// reads (yumi), commit (deq), rollback (roll) and flush (clr).
module bp_fe_fetch_queue
  import bp_fe_pkg::*;
#(
  parameter int unsigned els_p                       = fe_queue_els_dp,
  parameter int unsigned vaddr_width_p               = fe_vaddr_width_dp,
  parameter int unsigned instr_width_p               = fe_instr_width_dp,
  parameter int unsigned branch_metadata_fwd_width_p = fe_branch_metadata_width_dp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   fetch_v_i,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
  output logic                                   fetch_ready_o,
  output logic                                   fe_queue_v_o,
  output logic [vaddr_width_p-1:0]               fe_queue_pc_o,
  output logic [instr_width_p-1:0]               fe_queue_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] fe_queue_br_metadata_o,
  input  logic                                   fe_queue_yumi_i,
  input  logic                                   deq_v_i,
  input  logic                                   roll_v_i,
  input  logic                                   clr_v_i
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp = idx_width_lp + 1;

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic [instr_width_p-1:0]               instr;
    logic [branch_metadata_fwd_width_p-1:0] br_metadata;
  } bp_fe_queue_entry_s;

  bp_fe_queue_entry_s storage [els_p];
  bp_fe_queue_entry_s entry_in;
  bp_fe_queue_entry_s head;

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] cptr_next;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    full;
  logic                    enq;
  logic                    yumi_ok;
  logic                    deq_ok;
  logic                    roll;

  // Occupancy, handshake qualification and the rollback target
  always_comb begin
    occupancy = wptr - cptr;
    full      = (occupancy == ptr_width_lp'(els_p));
    enq       = fetch_v_i & ~full & ~clr_v_i;
    yumi_ok   = fe_queue_yumi_i & (rptr != wptr) & ~clr_v_i;
    deq_ok    = deq_v_i & (cptr != rptr) & ~clr_v_i;
    roll      = roll_v_i & ~clr_v_i;
    cptr_next = cptr + ptr_width_lp'(deq_ok);
  end

  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) wptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (enq),
    .load_i     (1'b0),
    .load_val_i ('0),
    .clr_i      (clr_v_i),
    .ptr_o      (wptr)
  );

  // Roll loads the commit pointer as it stands after this cycle's deq
  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) rptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (yumi_ok),
    .load_i     (roll),
    .load_val_i (cptr_next),
    .clr_i      (clr_v_i),
    .ptr_o      (rptr)
  );

  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) cptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (deq_ok),
    .load_i     (1'b0),
    .load_val_i ('0),
    .clr_i      (clr_v_i),
    .ptr_o      (cptr)
  );

  // Pack the incoming fetch packet
  always_comb begin
    entry_in.pc          = fetch_pc_i;
    entry_in.instr       = fetch_instr_i;
    entry_in.br_metadata = fetch_br_metadata_i;
  end

  // Packet storage, written at the tail; contents are not reset
  always_ff @(posedge clk_i) begin
    if (enq) storage[wptr[idx_width_lp-1:0]] <= entry_in;
  end

  // Combinational head read and status outputs
  always_comb begin
    head                   = storage[rptr[idx_width_lp-1:0]];
    fe_queue_v_o           = (rptr != wptr);
    fetch_ready_o          = ~full;
    fe_queue_pc_o          = head.pc;
    fe_queue_instr_o       = head.instr;
    fe_queue_br_metadata_o = head.br_metadata;
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);

  a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_v_i |-> (cptr != rptr));

  a_ptr_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((rptr - cptr) <= (wptr - cptr)) && ((wptr - cptr) <= ptr_width_lp'(els_p)));

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed bench for bp_fe_fetch_queue with a scoreboard of expected head PCs.
module tb_bp_fe_fetch_queue;

  localparam int unsigned VW = 39;
  localparam int unsigned IW = 32;
  localparam int unsigned MW = 36;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_v;
  logic [VW-1:0] fetch_pc;
  logic [IW-1:0] fetch_instr;
  logic [MW-1:0] fetch_meta;
  logic          fetch_ready;
  logic          q_v;
  logic [VW-1:0] q_pc;
  logic [IW-1:0] q_instr;
  logic [MW-1:0] q_meta;
  logic          yumi;
  logic          deq;
  logic          roll;
  logic          clr;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] exp_pc;

  always #5 clk = ~clk;

  bp_fe_fetch_queue #(
    .els_p                       (8),
    .vaddr_width_p               (VW),
    .instr_width_p               (IW),
    .branch_metadata_fwd_width_p (MW)
  ) dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n),
    .fetch_v_i              (fetch_v),
    .fetch_pc_i             (fetch_pc),
    .fetch_instr_i          (fetch_instr),
    .fetch_br_metadata_i    (fetch_meta),
    .fetch_ready_o          (fetch_ready),
    .fe_queue_v_o           (q_v),
    .fe_queue_pc_o          (q_pc),
    .fe_queue_instr_o       (q_instr),
    .fe_queue_br_metadata_o (q_meta),
    .fe_queue_yumi_i        (yumi),
    .deq_v_i                (deq),
    .roll_v_i               (roll),
    .clr_v_i                (clr)
  );

  function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
    return pc[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [MW-1:0] meta_of(input logic [VW-1:0] pc);
    return {4'hA, pc[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_v     = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
    fetch_meta  = '0;
    yumi        = 1'b0;
    deq         = 1'b0;
    roll        = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic set_fetch(input logic [VW-1:0] pc);
    fetch_v     = 1'b1;
    fetch_pc    = pc;
    fetch_instr = instr_of(pc);
    fetch_meta  = meta_of(pc);
  endtask

  task automatic set_yumi(input logic [VW-1:0] pc);
    yumi = 1'b1;
    exp_q.push_back(pc);
  endtask

  // Monitor: every consumed head must match the oldest expected packet
  always @(negedge clk) begin
    if (reset_n && yumi) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL yumi_unexpected: got head pc 0x%0h expected no consumption", q_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("head_v", 64'(q_v), 64'(1));
        chk("head_pc", 64'(q_pc), 64'(exp_pc));
        chk("head_instr", 64'(q_instr), 64'(instr_of(exp_pc)));
        chk("head_meta", 64'(q_meta), 64'(meta_of(exp_pc)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_v", 64'(q_v), 64'(0));
    chk("reset_ready", 64'(fetch_ready), 64'(1));
    step();
    step();
    reset_n = 1'b1;

    // Reset asserted mid-traffic clears the queue immediately
    set_fetch(39'h100);
    step();
    set_fetch(39'h104);
    step();
    chk("pre_reset_v", 64'(q_v), 64'(1));
    idle();
    reset_n = 1'b0;
    #1;
    chk("midreset_v", 64'(q_v), 64'(0));
    chk("midreset_ready", 64'(fetch_ready), 64'(1));
    step();
    reset_n = 1'b1;

    // First packet after reset: visible one cycle later, no bypass
    set_fetch(39'h8000_0000);
    #2;
    chk("enq_no_bypass_v", 64'(q_v), 64'(0));
    step();
    idle();
    chk("enq_latency_v", 64'(q_v), 64'(1));
    set_yumi(39'h8000_0000);
    step();
    idle();
    deq = 1'b1;
    step();
    idle();
    chk("post_first_v", 64'(q_v), 64'(0));

    // Fill to capacity
    for (int i = 0; i < 8; i++) begin
      set_fetch(39'h1000 + 39'(4 * i));
      chk("fill_ready", 64'(fetch_ready), 64'(1));
      step();
    end
    idle();
    chk("full_ready", 64'(fetch_ready), 64'(0));
    set_fetch(39'h2000);
    step();
    idle();
    chk("full_still_ready", 64'(fetch_ready), 64'(0));
    for (int i = 0; i < 8; i++) begin
      set_yumi(39'h1000 + 39'(4 * i));
      step();
    end
    idle();
    chk("drop_9th_v", 64'(q_v), 64'(0));

    // Full + deq: enqueue refused that cycle, accepted the next
    deq = 1'b1;
    set_fetch(39'h3000);
    chk("fulldeq_ready", 64'(fetch_ready), 64'(0));
    step();
    deq = 1'b0;
    chk("fulldeq_refused_v", 64'(q_v), 64'(0));
    chk("fulldeq_ready_after", 64'(fetch_ready), 64'(1));
    step();
    idle();
    chk("fulldeq_accept_v", 64'(q_v), 64'(1));
    set_yumi(39'h3000);
    step();
    idle();
    chk("fulldeq_once_v", 64'(q_v), 64'(0));
    for (int i = 0; i < 8; i++) begin
      deq = 1'b1;
      step();
    end
    idle();
    chk("drained_ready", 64'(fetch_ready), 64'(1));

    // Lockstep enqueue / yumi / deq across two pointer wraps
    for (int i = 0; i < 22; i++) begin
      idle();
      if (i < 20) set_fetch(39'h4000 + 39'(4 * i));
      if (i >= 1 && i <= 20) set_yumi(39'h4000 + 39'(4 * (i - 1)));
      if (i >= 2) deq = 1'b1;
      chk("lockstep_ready", 64'(fetch_ready), 64'(1));
      step();
    end
    idle();
    chk("lockstep_empty_v", 64'(q_v), 64'(0));

    // Rollback
    set_fetch(39'h5000);
    step();
    set_fetch(39'h5004);
    set_yumi(39'h5000);
    step();
    set_fetch(39'h5008);
    set_yumi(39'h5004);
    step();
    idle();
    deq = 1'b1;
    step();
    idle();
    roll = 1'b1;
    step();
    idle();
    chk("roll_v", 64'(q_v), 64'(1));
    chk("roll_head", 64'(q_pc), 64'(39'h5004));
    set_yumi(39'h5004);
    step();
    idle();
    deq  = 1'b1;
    roll = 1'b1;
    step();
    idle();
    chk("rolldeq_v", 64'(q_v), 64'(1));
    chk("rolldeq_head", 64'(q_pc), 64'(39'h5008));
    set_yumi(39'h5008);
    step();
    idle();
    deq = 1'b1;
    step();
    idle();
    chk("roll_empty_v", 64'(q_v), 64'(0));

    // Clear overrides same-cycle enqueue and yumi
    for (int i = 0; i < 5; i++) begin
      set_fetch(39'h6000 + 39'(4 * i));
      step();
    end
    idle();
    clr = 1'b1;
    set_fetch(39'h7000);
    set_yumi(39'h6000);
    step();
    idle();
    chk("clr_v", 64'(q_v), 64'(0));
    chk("clr_ready", 64'(fetch_ready), 64'(1));
    step();
    chk("clr_absent_v", 64'(q_v), 64'(0));
    set_fetch(39'h8000);
    step();
    idle();
    chk("post_clr_v", 64'(q_v), 64'(1));
    set_yumi(39'h8000);
    step();
    idle();
    deq = 1'b1;
    step();
    idle();
    step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
